// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite OAM DMA controller: copies one 256-byte page into PPU OAM
//
// Ports:
//   cpu_clk    system clock, rising edge
//   reset      synchronous, active-high
//   bus_addr   CPU bus address (trigger detect)
//   bus_din    CPU write data, page number on trigger
//   bus_wr     0 = CPU write, 1 = CPU read
//   odd_cycle  CPU cycle parity, 1 = odd
//   oam_start  PPU OAMADDR, latched at trigger
//   rd_data    memory read data, valid the cycle after dma_addr
//   hijack     DMA owns the bus
//   dma_addr   source read address
//   oam_addr   OAM write address
//   oam_data   OAM write data
//   oam_we     OAM write strobe
//   done       one-cycle completion pulse
module oam_dma_ctrl #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter bit          ALIGN_EN     = 1'b1
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    input  logic        odd_cycle,
    input  logic [7:0]  oam_start,
    input  logic [7:0]  rd_data,
    output logic        hijack,
    output logic [15:0] dma_addr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        hijack_q;
    logic [15:0] dma_addr_q;
    logic [7:0]  oam_addr_q;
    logic        oam_we_q;
    logic        done_q;
    logic        trigger;

    // Only an idle controller accepts a trigger, so writes during a transfer are dropped.
    assign trigger = (state_q == IDLE) && (bus_addr == TRIGGER_ADDR) && !bus_wr;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = HALT;
                    page_d  = bus_din;
                    cnt_d   = 8'h00;
                    ptr_d   = oam_start;
                end
            end
            HALT:    state_d = (ALIGN_EN && odd_cycle) ? ALIGN : READ;
            ALIGN:   state_d = READ;
            READ:    state_d = WRITE;
            WRITE: begin
                // 8-bit wrap on both counters; no carry into the page byte.
                cnt_d   = cnt_q + 8'd1;
                ptr_d   = ptr_q + 8'd1;
                state_d = (cnt_q != 8'hFF) ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            page_q     <= 8'h00;
            cnt_q      <= 8'h00;
            ptr_q      <= 8'h00;
            hijack_q   <= 1'b0;
            dma_addr_q <= 16'h0000;
            oam_addr_q <= 8'h00;
            oam_we_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            hijack_q   <= (state_d != IDLE);
            dma_addr_q <= ((state_d == READ) || (state_d == WRITE)) ? {page_d, cnt_d} : 16'h0000;
            oam_addr_q <= ptr_d;
            oam_we_q   <= (state_d == WRITE);
            done_q     <= (state_q == WRITE) && (state_d == IDLE);
        end
    end

    assign hijack   = hijack_q;
    assign dma_addr = dma_addr_q;
    assign oam_addr = oam_addr_q;
    assign oam_we   = oam_we_q;
    assign done     = done_q;
    // rd_data arrives in the WRITE cycle itself, so it is forwarded rather than registered.
    assign oam_data = oam_we_q ? rd_data : 8'h00;

endmodule
